switch_input_capture: RTL and testbench



---
 rtl/switch_input_capture.sv | 109 ++++++++++
 tb/tb_switch_input_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_capture.sv
// Enter-value front end: synchronises the switches and enter button, debounces the button,
// and hands one captured switch value per request to the core over a valid/ack handshake.
module switch_input_capture #(
    parameter int unsigned DEBOUNCE_CNT = 50000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       btn_enter,
    input  logic       in_req,
    input  logic       in_ack,
    output logic [7:0] in_data,
    output logic       in_valid,
    output logic       inp_take,
    output logic [7:0] disp_val
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        VALID,
        WAIT_RELEASE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    logic [7:0]       sw_meta_q, sw_s_q;
    logic             btn_meta_q, btn_s_q;
    logic             btn_db_q, btn_db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_prev_q, press_q;
    state_e           state_q, state_d;
    logic [7:0]       in_data_q, in_data_d;

    // A new button level is accepted only after DEBOUNCE_CNT consecutive differing cycles.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        btn_db_d = btn_db_q;
        cnt_d    = '0;
        if (btn_s_q != btn_db_q) begin
            if (cnt_q == CNT_MAX) begin
                btn_db_d = btn_s_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_data_d = in_data_q;
        unique case (state_q)
            IDLE: begin
                if (in_req) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                // Abort wins over a press arriving in the same cycle.
                if (!in_req) begin
                    state_d = IDLE;
                end else if (press_q) begin
                    in_data_d = sw_s_q;
                    state_d   = VALID;
                end
            end
            VALID: begin
                if (in_ack) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // Holding off until release stops one long press feeding two requests.
                if (!btn_db_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            btn_db_q   <= 1'b0;
            cnt_q      <= '0;
            db_prev_q  <= 1'b0;
            press_q    <= 1'b0;
            state_q    <= IDLE;
            in_data_q  <= '0;
        end else begin
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            btn_meta_q <= btn_enter;
            btn_s_q    <= btn_meta_q;
            btn_db_q   <= btn_db_d;
            cnt_q      <= cnt_d;
            db_prev_q  <= btn_db_q;
            press_q    <= btn_db_q & ~db_prev_q;
            state_q    <= state_d;
            in_data_q  <= in_data_d;
        end
    end

    assign in_data  = in_data_q;
    assign in_valid = (state_q == VALID);
    assign inp_take = (state_q == WAIT_PRESS);
    assign disp_val = (state_q == WAIT_PRESS) ? sw_s_q : in_data_q;

endmodule

// File: tb/tb_switch_input_capture.sv
// Directed bench for switch_input_capture with DEBOUNCE_CNT=4; expected values are hand-derived.
module tb_switch_input_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic       btn_enter;
    logic       in_req;
    logic       in_ack;
    logic [7:0] in_data;
    logic       in_valid;
    logic       inp_take;
    logic [7:0] disp_val;

    int n_checks = 0;
    int n_errors = 0;

    switch_input_capture #(
        .DEBOUNCE_CNT(4),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_enter(btn_enter),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .in_valid (in_valid),
        .inp_take (inp_take),
        .disp_val (disp_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (!in_valid && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, in_valid}, 32'd1);
    endtask

    logic seen_valid;
    logic lost_valid;
    logic lost_take;

    initial begin
        rst_n     = 1'b0;
        sw        = 8'h00;
        btn_enter = 1'b0;
        in_req    = 1'b0;
        in_ack    = 1'b0;
        #12;
        check("rst_in_valid", {31'd0, in_valid}, 32'd0);
        check("rst_inp_take", {31'd0, inp_take}, 32'd0);
        check("rst_in_data",  {24'd0, in_data},  32'd0);
        check("rst_disp_val", {24'd0, disp_val}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Normal capture
        in_req = 1'b1;
        sw     = 8'h7B;
        tick(1);
        check("norm_take", {31'd0, inp_take}, 32'd1);
        tick(1);
        check("norm_disp_7b", {24'd0, disp_val}, 32'h7B);
        sw = 8'h05;
        tick(1);
        check("norm_disp_lag", {24'd0, disp_val}, 32'h7B);
        tick(1);
        check("norm_disp_05", {24'd0, disp_val}, 32'h05);
        btn_enter = 1'b1;
        tick(7);
        check("norm_valid_early", {31'd0, in_valid}, 32'd0);
        tick(1);
        check("norm_valid_at8", {31'd0, in_valid}, 32'd1);
        check("norm_data", {24'd0, in_data}, 32'h05);
        check("norm_take_off", {31'd0, inp_take}, 32'd0);
        tick(2);
        btn_enter = 1'b0;
        in_ack    = 1'b1;
        in_req    = 1'b0;
        tick(1);
        in_ack = 1'b0;
        check("norm_ack_clears", {31'd0, in_valid}, 32'd0);
        tick(10);
        check("norm_disp_hold", {24'd0, disp_val}, 32'h05);
        in_req = 1'b1;
        tick(1);
        check("norm_back_idle", {31'd0, inp_take}, 32'd1);

        // Bounce rejection
        seen_valid = 1'b0;
        lost_take  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn_enter = 1'b1;
            tick(1); seen_valid |= in_valid; lost_take |= ~inp_take;
            tick(1); seen_valid |= in_valid; lost_take |= ~inp_take;
            btn_enter = 1'b0;
            tick(1); seen_valid |= in_valid; lost_take |= ~inp_take;
            tick(1); seen_valid |= in_valid; lost_take |= ~inp_take;
        end
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen_valid |= in_valid;
            lost_take  |= ~inp_take;
        end
        check("bounce_no_valid", {31'd0, seen_valid}, 32'd0);
        check("bounce_take_held", {31'd0, lost_take}, 32'd0);

        // Abort
        sw = 8'h33;
        tick(3);
        check("abort_disp_sw", {24'd0, disp_val}, 32'h33);
        in_req = 1'b0;
        tick(1);
        check("abort_take", {31'd0, inp_take}, 32'd0);
        check("abort_data", {24'd0, in_data}, 32'h05);
        check("abort_disp", {24'd0, disp_val}, 32'h05);
        in_ack = 1'b1;
        tick(1);
        in_ack = 1'b0;
        check("ack_idle_noeffect", {31'd0, in_valid}, 32'd0);

        // Held-button request
        btn_enter = 1'b1;
        tick(10);
        in_req = 1'b1;
        tick(1);
        check("held_take", {31'd0, inp_take}, 32'd1);
        tick(10);
        check("held_no_capture", {31'd0, in_valid}, 32'd0);
        btn_enter = 1'b0;
        sw        = 8'hFF;
        tick(6);
        btn_enter = 1'b1;
        wait_valid("held_repress_valid", 20);
        check("held_data", {24'd0, in_data}, 32'hFF);

        // Hold until ack with in_req dropped
        in_req     = 1'b0;
        lost_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            lost_valid |= ~in_valid;
        end
        check("hold_valid_50", {31'd0, lost_valid}, 32'd0);
        check("hold_data", {24'd0, in_data}, 32'hFF);
        in_ack = 1'b1;
        tick(1);
        in_ack = 1'b0;
        check("hold_ack", {31'd0, in_valid}, 32'd0);

        // Double request: button still held after ack
        in_req = 1'b1;
        sw     = 8'h11;
        tick(20);
        check("dbl_no_take", {31'd0, inp_take}, 32'd0);
        check("dbl_no_valid", {31'd0, in_valid}, 32'd0);
        btn_enter = 1'b0;
        tick(8);
        check("dbl_take_after_rel", {31'd0, inp_take}, 32'd1);
        check("dbl_data_kept", {24'd0, in_data}, 32'hFF);
        btn_enter = 1'b1;
        wait_valid("dbl_fresh_valid", 20);
        check("dbl_data", {24'd0, in_data}, 32'h11);
        in_ack    = 1'b1;
        in_req    = 1'b0;
        btn_enter = 1'b0;
        tick(1);
        in_ack = 1'b0;
        tick(10);

        // Reset mid-VALID
        sw     = 8'h2A;
        in_req = 1'b1;
        tick(3);
        btn_enter = 1'b1;
        wait_valid("rstv_valid", 20);
        check("rstv_data", {24'd0, in_data}, 32'h2A);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstv_in_valid", {31'd0, in_valid}, 32'd0);
        check("rstv_inp_take", {31'd0, inp_take}, 32'd0);
        check("rstv_in_data",  {24'd0, in_data},  32'd0);
        check("rstv_disp_val", {24'd0, disp_val}, 32'd0);
        in_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        lost_take  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            seen_valid |= in_valid;
            lost_take  |= inp_take;
        end
        check("rstv_press_ignored", {31'd0, seen_valid}, 32'd0);
        check("rstv_idle", {31'd0, lost_take}, 32'd0);
        check("rstv_data_zero", {24'd0, in_data}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
